// File: rtl/common_bus_datapath.sv
// common_bus_datapath
// Shared 8-bit bus datapath driven by the microcode sequencer: PC, IR,
// register-select latch, 8-entry register file, ALU source registers, ALU
// and Z/C flags. Every state element loads from the one bus value present at
// the clock edge; IR loads from the instruction memory instead.
// Optional build macro: CB_R0_ZERO_EN -- rf[0] reads as zero and ignores
// writes. Without the macro rf[0] is an ordinary register.
module common_bus_datapath #(
    parameter int DATA_W  = 8,
    parameter int IR_W    = 16,
    parameter int PC_INCR = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        data_bus_sel,
    input  logic              pc_load_en,
    input  logic              ir_load_en,
    input  logic              rf_write_read,
    input  logic              alu_src1_load_en,
    input  logic              alu_src2_load_en,
    input  logic              sel_field_load_en,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imm_instruction,
    output logic [DATA_W-1:0] data_bus,
    output logic              flag_z,
    output logic              flag_c
);

    // Bus source encoding
    localparam logic [2:0] BUS_ZERO      = 3'd0;
    localparam logic [2:0] BUS_IR_R1     = 3'd1;
    localparam logic [2:0] BUS_IR_R2     = 3'd2;
    localparam logic [2:0] BUS_IR_RD     = 3'd3;
    localparam logic [2:0] BUS_RF        = 3'd4;
    localparam logic [2:0] BUS_ALU       = 3'd5;
    localparam logic [2:0] BUS_PC_PLUS_4 = 3'd6;
    localparam logic [2:0] BUS_RSV       = 3'd7;

    // ALU operation encoding (IR[15:13])
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLL  = 3'd5;
    localparam logic [2:0] OP_SRL  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic [DATA_W-1:0] pc_r;
    logic [IR_W-1:0]   ir_r;
    logic [2:0]        sel_r;
    logic [DATA_W-1:0] src1_r;
    logic [DATA_W-1:0] src2_r;
    logic [DATA_W-1:0] rf_r [0:7];
    logic              flag_z_r;
    logic              flag_c_r;

    logic [2:0]        alu_op_s;
    logic              imm_s;
    logic [DATA_W-1:0] ir_r1_s;
    logic [DATA_W-1:0] ir_r2_s;
    logic [DATA_W-1:0] ir_rd_s;
    logic [DATA_W-1:0] rf_rd_s;
    logic [DATA_W:0]   alu_res_s;
    logic [DATA_W-1:0] pc_plus_s;
    logic [DATA_W-1:0] bus_s;
    logic              rf_we_s;
    logic              flag_we_s;

    // IR field decode; all fields come from the registered IR so they are
    // stable for the whole cycle after the IR load
    assign alu_op_s  = ir_r[15:13];
    assign imm_s     = ir_r[12];
    assign ir_rd_s   = {{(DATA_W-3){1'b0}}, ir_r[11:9]};
    assign ir_r1_s   = {{(DATA_W-3){1'b0}}, ir_r[8:6]};
    assign pc_plus_s = pc_r + DATA_W'(PC_INCR);

    // Second-operand field: full 6-bit immediate or 3-bit register index
    always_comb begin
        if (imm_s) begin
            ir_r2_s = {{(DATA_W-6){1'b0}}, ir_r[5:0]};
        end else begin
            ir_r2_s = {{(DATA_W-3){1'b0}}, ir_r[2:0]};
        end
    end

`ifdef CB_R0_ZERO_EN
    // Register file read port with r0 hard-wired to zero
    always_comb begin
        if (sel_r == 3'd0) begin
            rf_rd_s = '0;
        end else begin
            rf_rd_s = rf_r[sel_r];
        end
    end

    // Writes aimed at r0 are dropped
    assign rf_we_s = rf_write_read && (sel_r != 3'd0);
`else
    // Register file read port, no write-through bypass
    assign rf_rd_s = rf_r[sel_r];
    assign rf_we_s = rf_write_read;
`endif

    // ALU with a carry/borrow bit above the data width; logic ops and shifts
    // leave that bit clear by construction
    always_comb begin
        alu_res_s = '0;
        case (alu_op_s)
            OP_ADD:  alu_res_s = {1'b0, src1_r} + {1'b0, src2_r};
            OP_SUB:  alu_res_s = {1'b0, src1_r} - {1'b0, src2_r};
            OP_AND:  alu_res_s = {1'b0, src1_r & src2_r};
            OP_OR:   alu_res_s = {1'b0, src1_r | src2_r};
            OP_XOR:  alu_res_s = {1'b0, src1_r ^ src2_r};
            OP_SLL:  alu_res_s = {1'b0, src1_r << src2_r[2:0]};
            OP_SRL:  alu_res_s = {1'b0, src1_r >> src2_r[2:0]};
            OP_PASS: alu_res_s = {1'b0, src2_r};
            default: alu_res_s = '0;
        endcase
    end

    // Shared bus source mux; the reserved code drives zero
    always_comb begin
        bus_s = '0;
        case (data_bus_sel)
            BUS_ZERO:      bus_s = '0;
            BUS_IR_R1:     bus_s = ir_r1_s;
            BUS_IR_R2:     bus_s = ir_r2_s;
            BUS_IR_RD:     bus_s = ir_rd_s;
            BUS_RF:        bus_s = rf_rd_s;
            BUS_ALU:       bus_s = alu_res_s[DATA_W-1:0];
            BUS_PC_PLUS_4: bus_s = pc_plus_s;
            BUS_RSV:       bus_s = '0;
            default:       bus_s = '0;
        endcase
    end

    // Flags only capture an ALU result that is being written back
    assign flag_we_s = rf_write_read && (data_bus_sel == BUS_ALU);

    // PC, IR, select latch and ALU source registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r   <= '0;
            ir_r   <= '0;
            sel_r  <= 3'd0;
            src1_r <= '0;
            src2_r <= '0;
        end else begin
            if (pc_load_en) begin
                pc_r <= bus_s;
            end
            if (ir_load_en) begin
                ir_r <= imem_rdata;
            end
            if (sel_field_load_en) begin
                sel_r <= bus_s[2:0];
            end
            if (alu_src1_load_en) begin
                src1_r <= bus_s;
            end
            if (alu_src2_load_en) begin
                src2_r <= bus_s;
            end
        end
    end

    // Register file write; indexed by the select value before this edge
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[3'(i)] <= '0;
            end
        end else begin
            if (rf_we_s) begin
                rf_r[sel_r] <= bus_s;
            end
        end
    end

    // Zero and carry flags
    always_ff @(posedge clock) begin
        if (reset) begin
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
        end else begin
            if (flag_we_s) begin
                flag_z_r <= (alu_res_s[DATA_W-1:0] == '0);
                flag_c_r <= alu_res_s[DATA_W];
            end
        end
    end

    assign imem_addr       = pc_r;
    assign imm_instruction = ir_r[12];
    assign data_bus        = bus_s;
    assign flag_z          = flag_z_r;
    assign flag_c          = flag_c_r;

endmodule
